// File: rtl/int_sqrt_pkg.sv
// Shared types and width helpers for the integer square-root block.
package int_sqrt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int ceil_half(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/int_sqrt_rem_if.sv
// Handshake bundle: radicand/mode in, root/remainder out.
interface int_sqrt_rem_if
  import int_sqrt_pkg::*;
#(
  parameter int N = 32
);
  localparam int M = ceil_half(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [M:0]   root;
  logic [M:0]   rem;

  modport master (
    output in_valid, in, mode, out_ready,
    input  in_ready, out_valid, root, rem
  );

  modport slave (
    input  in_valid, in, mode, out_ready,
    output in_ready, out_valid, root, rem
  );
endinterface

// File: rtl/int_sqrt_step.sv
// One restoring digit-by-digit iteration: bring down a bit pair, try to subtract 4q+1.
module int_sqrt_step #(
  parameter int M = 16
) (
  input  logic [M:0]   rem_i,
  input  logic [M-1:0] root_i,
  input  logic [1:0]   pair_i,
  output logic [M:0]   rem_o,
  output logic         bit_o
);
  localparam int W = M + 3;

  logic [W-1:0] acc;
  logic [W-1:0] sub;
  logic [M:0]   diff;

  // The surviving remainder always fits M+1 bits, so the low-bit difference is exact.
  always_comb begin
    acc   = {rem_i, pair_i};
    sub   = {1'b0, root_i, 2'b01};
    bit_o = (acc >= sub);
    diff  = acc[M:0] - sub[M:0];
    rem_o = bit_o ? diff : acc[M:0];
  end
endmodule

// File: rtl/int_sqrt_rem.sv
// Sequential integer square root: one root bit per cycle, optional round-to-nearest.
module int_sqrt_rem
  import int_sqrt_pkg::*;
#(
  parameter int N = 32
) (
  input logic           clk,
  input logic           rst,
  int_sqrt_rem_if.slave bus
);
  localparam int M  = ceil_half(N);
  localparam int XW = 2 * M;
  localparam int CW = $clog2(M + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [XW-1:0]  x_q,     x_d;
  logic           mode_q,  mode_d;
  logic [M:0]     rem_q,   rem_d;
  logic [M-1:0]   q_q,     q_d;
  logic [M:0]     root_o_q, root_o_d;
  logic [M:0]     rem_o_q,  rem_o_d;

  logic [M:0]     step_rem;
  logic           step_bit;
  logic [M:0]     floor_ext;

  int_sqrt_step #(.M(M)) u_step (
    .rem_i  (rem_q),
    .root_i (q_q),
    .pair_i (x_q[XW-1 -: 2]),
    .rem_o  (step_rem),
    .bit_o  (step_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      mode_q   <= 1'b0;
      rem_q    <= '0;
      q_q      <= '0;
      root_o_q <= '0;
      rem_o_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      root_o_q <= root_o_d;
      rem_o_q  <= rem_o_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    q_d       = q_q;
    root_o_d  = root_o_q;
    rem_o_d   = rem_o_q;
    floor_ext = {1'b0, q_q};

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_CALC;
          x_d     = XW'(bus.in);  // odd N: implicit zero MSB pads to whole pairs
          mode_d  = bus.mode;
          rem_d   = '0;
          q_d     = '0;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        q_d   = M'({q_q, step_bit});
        x_d   = x_q << 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(M - 1)) begin
          state_d = S_ROUND;
          cnt_d   = '0;
        end
      end
      S_ROUND: begin
        // rem > floor means x sits past floor+0.5 squared; carry lands in the extra root bit
        root_o_d = (mode_q && (rem_q > floor_ext)) ? floor_ext + 1'b1 : floor_ext;
        rem_o_d  = rem_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.root      = root_o_q;
  assign bus.rem       = rem_o_q;
endmodule
